// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Radix-2 multiply/divide beside the EX-stage ALU. One step per cycle for
// WIDTH cycles, then a sign-fix/writeback cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, op       issue request (accepted only when idle); 00 MULT, 01 MULTU,
//                   10 DIV, 11 DIVU
//   a, b            rs / rt operands
//   hi_we, lo_we    MTHI / MTLO strobes with data on wdata (idle only)
//   busy            operation in flight
//   done            one-cycle pulse after HI/LO are written
//   hi, lo          architectural HI / LO registers

module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic               is_div;
  logic               neg_res;   // negate product / quotient
  logic               neg_rem;   // remainder takes dividend's sign
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;     // kept for the divide-by-zero HI result
  logic [WIDTH-1:0]   opnd;      // multiplicand for multiply, divisor for divide
  logic [2*WIDTH-1:0] acc;       // {upper, lower}: product or {remainder, quotient}
  logic [CNT_W-1:0]   cnt;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign busy = (state != S_IDLE);

  // Sign handling only for the signed ops (op[0] == 0).
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Shifted partial remainder minus divisor; bit WIDTH set means "does not fit".
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op[1] & (b == '0);
            a_raw    <= a;
            cnt      <= '0;
            if (op[1]) begin
              opnd <= abs_b;
              acc  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              acc  <= {{WIDTH{1'b0}}, abs_b};
            end
            state <= S_RUN;
          end else begin
            // MTHI/MTLO only land when no operation is being issued.
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (div_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed scoreboard bench for muldiv_iter

module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int e0 = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; drives start for exactly one edge (E0).
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] e);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  // Waits (bounded) for done, checks latency, busy window and the popped result.
  task automatic wait_result(input string tag);
    logic        busy_ok;
    logic [63:0] e;
    int          lat;
    busy_ok = 1'b1;
    @(negedge clk);
    while (!done && (cyc - e0) < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    lat = cyc - e0;
    check({tag, "_latency"}, lat, 33);
    check({tag, "_busy_window"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_low_at_done"}, {31'b0, busy}, 32'd0);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
  endtask

  int pulses;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait_result("multu_max");
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);

    start_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    wait_result("mult_neg");
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);  // issued on done cycle
    wait_result("div_b2b");

    start_op(OP_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);
    wait_result("divu_zero");
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    wait_result("div_ovf");
    start_op(OP_DIVU, 32'h80000000, 32'd3, 64'h00000002_2AAAAAAA);
    wait_result("divu_3");
    start_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    wait_result("div_neg_divisor");
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    wait_result("div_zero_signed");
    start_op(OP_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    wait_result("mult_minmin");

    // Interlopers while busy: a second start and an MTHI are both ignored.
    start_op(OP_DIVU, 32'd50, 32'd7, 64'h00000001_00000007);
    repeat (4) @(negedge clk);
    op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    wait_result("divu_interlope");
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("interlope_no_extra_done", pulses, 0);
    check("interlope_hi_kept", hi, 32'd1);

    // Idle MTHI / MTLO.
    hi_we = 1'b1; wdata = 32'hDEAD0000;
    @(posedge clk); #1 hi_we = 1'b0;
    check("mthi", hi, 32'hDEAD0000);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000BEEF;
    @(posedge clk); #1 lo_we = 1'b0;
    check("mtlo", lo, 32'h0000BEEF);
    check("mtlo_hi_kept", hi, 32'hDEAD0000);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5555AAAA;
    start_op(OP_MULTU, 32'h00012345, 32'h00010000, 64'h00000001_23450000);
    lo_we = 1'b0;
    check("start_wins_lo_hold", lo, 32'h0000BEEF);
    wait_result("start_with_mtlo");

    // Reset in flight abandons the operation.
    @(negedge clk);
    start_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 64'h0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    exp_q.delete();
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", pulses, 0);
    check("rst_lo_still_zero", lo, 32'h0);
    start_op(OP_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A);
    wait_result("multu_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative integer multiply/divide unit for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds the results in architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. It sits beside the EX-stage ALU; the hazard unit ORs `busy` into its pipeline stall.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width; must be at least 2.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: issue request; accepted only when `busy`=0.
- `op`, input, 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`, input, WIDTH: rs operand (multiplicand or dividend).
- `b`, input, WIDTH: rt operand (multiplier or divisor).
- `hi_we`, input, 1: MTHI write strobe.
- `lo_we`, input, 1: MTLO write strobe.
- `wdata`, input, WIDTH: MTHI/MTLO data.
- `busy`, output, 1: operation in flight.
- `done`, output, 1: one-cycle pulse; HI/LO updated.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation

- States:
  - IDLE.
  - RUN: WIDTH iterations.
  - FIX: sign correction and HI/LO writeback.
- IDLE, `start`=1: latch `op`, |a|, |b| and the sign flags, then go to RUN with counter=0. Absolute values apply to signed ops only; unsigned ops use raw operands.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After counter reaches WIDTH-1, go to FIX.
- FIX, multiply: negate the 2*WIDTH product if the operand signs differ (MULT only). Write the upper half to HI and the lower half to LO.
- FIX, divide: negate the quotient if the signs differ; the remainder takes the dividend's sign (DIV only). Write the quotient to LO and the remainder to HI.
- FIX then returns to IDLE, asserting `done`.
- Divide by zero (`b`=0, DIV or DIVU): LO = all ones, HI = `a`. The operation still takes the full latency.
- Signed overflow (DIV, `a` = most negative, `b` = -1): LO = `a`, HI = 0.
- `busy`=1 in RUN and FIX; `busy`=0 in IDLE.
- `start` while `busy`=1 is ignored; the issuer holds the instruction via stall.
- `hi_we`/`lo_we` in IDLE: the register is written at the clock edge.
- `hi_we`/`lo_we` while `busy`=1 are dropped.
- `start` together with `hi_we`/`lo_we` in the same IDLE cycle: start wins and the writes are dropped.
- `hi`/`lo` hold their previous values throughout RUN; there are no partial-result updates.
- Reset:
  - Any state goes to IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Internal accumulator and counter are cleared.
  - An operation in flight is abandoned with no writeback.

## Timing

- Edge E0 samples `start`=1 in IDLE.
- `busy`=1 from after E0 until edge E0+WIDTH+1.
- RUN occupies edges E1..E(WIDTH); FIX is the cycle ending at edge E(WIDTH+1).
- HI/LO update at E(WIDTH+1). After that edge: `done`=1 for exactly one cycle, `busy`=0.
- Latency from start to result visible is WIDTH+1 cycles (33 for WIDTH=32).
- A new `start` is accepted in the same cycle `done`=1 (back-to-back issue). The next result arrives WIDTH+1 cycles later.
- MTHI/MTLO writes: one cycle latency.
- `hi`/`lo`/`busy`/`done` are registered outputs with no combinational path from inputs.

## Test plan

- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> `done` pulses at cycle 33 with hi=0xFFFFFFFE, lo=0x00000001; `busy` is high for cycles 1-33.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2 issued on the `done` cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, 33 cycles later.
- Divide corners:
  - DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU a=0x80000000 b=3 -> lo=0x2AAAAAAA, hi=2.
- Start DIVU 50/7, assert `start` (MULTU 2*2) at cycle 5, and assert `hi_we` with wdata=0x1234 at cycle 6 -> both ignored; final lo=7, hi=1, and only one `done` pulse.
- Idle writes: `hi_we` with 0xDEAD0000, then `lo_we` with 0x0000BEEF -> hi and lo read back after one cycle each. Then start together with `lo_we` -> the write is dropped and lo holds the op result.
- Start MULTU, assert `rst` at cycle 10 -> next cycle `busy`=0, hi=lo=0, and `done` never pulses. Then a fresh MULTU 6*7 -> lo=42, hi=0.
